serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/sub_bit_cell.sv | 17 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

    localparam int SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit subtract cell: full adder with the b input inverted.
// Ports: a, b, cin -> s (difference bit), cout (carry, 1 = no borrow).
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic nb;

    assign nb   = ~b;
    assign s    = a ^ nb ^ cin;
    assign cout = (a & nb) | (a & cin) | (nb & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per clock, start/done handshake.
// Ports: clk, rst_n, start, a, b -> busy, done, diff, borrow
//        (+ ovf when SERIAL_SUB_OVERFLOW_EN is defined).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_n;
    logic             carry;
    logic [CW-1:0]    count;
    logic             s;
    logic             cout;
    logic             last;
    logic             load;

    sub_bit_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (s),
        .cout (cout)
    );

    // Result enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
    assign r_n  = (r_sr >> 1) | {s, {(WIDTH-1){1'b0}}};
    assign last = (state == SHIFT) && (count == CW'(WIDTH - 1));
    assign load = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (last) state_n = DONE;
            DONE:    state_n = start ? SHIFT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            carry  <= 1'b1;
            count  <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == SHIFT);
            done  <= (state_n == DONE);
            if (load) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= 1'b1;
                count <= '0;
            end else if (state == SHIFT) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                r_sr  <= r_n;
                carry <= cout;
                if (!last) count <= count + CW'(1);
            end
            // Results are captured on the final shift so they are
            // already valid in the cycle done is high.
            if (last) begin
                diff   <= r_n;
                borrow <= ~cout;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // On the final shift, carry is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (last) ovf <= carry ^ cout;
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8).
// Covers ovf when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf    (ovf),
`endif
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change on negedge; cycle 1 is the cycle after the accept edge.
    task automatic run_op(input string tag, input int av, input int bv,
                          input int ed, input int eb, input int eo);
        int n;
        @(negedge clk);
        a = W'(av);
        b = W'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, ".busy"}, int'(busy), 1);
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, n, 9);
        check({tag, ".diff"}, int'(diff), ed);
        check({tag, ".borrow"}, int'(borrow), eb);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, ".ovf"}, int'(ovf), eo);
`else
        if (eo > 1) $display("note: bad ovf expectation in %s", tag);
`endif
        check({tag, ".idle"}, int'(busy), 0);
        @(negedge clk);
        check({tag, ".pulse"}, int'(done), 0);
    endtask

    initial begin
        int n;
        int ndone;

        #12;
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.diff", int'(diff), 0);
        check("rst.borrow", int'(borrow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("200-55", 200, 55, 145, 0, 0);
        run_op("5-10", 5, 10, 251, 1, 0);
        run_op("0-0", 0, 0, 0, 0, 0);
        run_op("127-255", 127, 255, 128, 1, 1);
        run_op("128-1", 128, 1, 127, 0, 1);
        run_op("255-255", 255, 255, 0, 0, 0);

        // start ignored while busy; start held through DONE chains an op
        @(negedge clk);
        a = 8'd10;
        b = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (done) ndone++;
            start = (c == 3) || (c == 5) || (c == 8);
            if (c == 3) begin
                a = 8'd99;
                b = 8'd1;
            end
            if (c == 8) begin
                a = 8'd20;
                b = 8'd6;
            end
        end
        check("ign.early_done", ndone, 0);
        @(negedge clk);
        check("ign.done", int'(done), 1);
        check("ign.diff", int'(diff), 7);
        @(negedge clk);
        start = 1'b0;
        check("b2b.busy", int'(busy), 1);
        check("b2b.done0", int'(done), 0);
        check("b2b.hold", int'(diff), 7);
        n = 10;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b.lat", n, 18);
        check("b2b.diff", int'(diff), 14);

        // reset in the middle of an operation
        @(negedge clk);
        a = 8'd77;
        b = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid.busy", int'(busy), 0);
        check("mid.done", int'(done), 0);
        check("mid.diff", int'(diff), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("mid.quiet", ndone, 0);
        run_op("77-7", 77, 7, 70, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
